// File: rtl/adder_pipe_acc.sv
// adder_pipe_acc: two-stage add/sub/accumulate unit with valid/ready handshakes and flags.
// Define ADDER_SAT_EN to clamp overflowing ADD/SUB/ACC results to signed max/min.
module adder_pipe_acc #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [WIDTH-1:0] acc_value
);
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ACC, OP_CLR} op_t;

    logic             s1_valid;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic             s1_advance;
    logic [WIDTH-1:0] opa, opb, res, sum_next;
    logic [WIDTH:0]   raw;
    logic             ovf, is_clr;

    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign is_clr     = s1_op == OP_CLR;

    // ACC reuses the adder with the accumulator as A and the operand as B'
    always_comb begin
        opa = s1_op == OP_ACC ? acc_value : s1_a;
        opb = s1_op == OP_SUB ? ~s1_b : s1_op == OP_ACC ? s1_a : s1_b;
        raw = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, s1_op == OP_SUB};
        ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (raw[WIDTH-1] != opa[WIDTH-1]);
`ifdef ADDER_SAT_EN
        res = ovf ? (opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                  : raw[WIDTH-1:0];
`else
        res = raw[WIDTH-1:0];
`endif
        sum_next = is_clr ? acc_value : res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op_t'(in_op);
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    // The accumulator only moves together with an output-register load, so ops stay ordered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            acc_value <= ACC_INIT;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum   <= sum_next;
                out_carry <= !is_clr && raw[WIDTH];
                out_ovf   <= !is_clr && ovf;
                out_zero  <= sum_next == '0;
                if (s1_op == OP_ACC) acc_value <= res;
                else if (is_clr) acc_value <= ACC_INIT;
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe_acc.sv
// tb_adder_pipe_acc: directed and random checks of adder_pipe_acc against an arithmetic scoreboard.
module tb_adder_pipe_acc;
    localparam logic [31:0] ACC_INIT = 32'h0;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [1:0]  in_op = 2'd0;
    logic [31:0] in_a = '0, in_b = '0, out_sum, acc_value;
    logic        out_carry, out_ovf, out_zero;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        o;
        logic [31:0] acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] macc = ACC_INIT;
    int          errors = 0, checks = 0;

    adder_pipe_acc #(.WIDTH(32), .ACC_INIT(ACC_INIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero),
        .acc_value(acc_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: true signed/unsigned arithmetic on wide integers, in acceptance order
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint t;
        logic [32:0] u;
        t = 0;
        e.c = 1'b0;
        e.o = 1'b0;
        if (o == 2'd3) begin
            e.sum = macc;
            macc  = ACC_INIT;
            e.acc = macc;
            return e;
        end
        if (o == 2'd0) begin
            t = longint'($signed(a)) + longint'($signed(b));
            u = {1'b0, a} + {1'b0, b};
            e.c = u[32];
        end else if (o == 2'd1) begin
            t = longint'($signed(a)) - longint'($signed(b));
            e.c = a >= b;
        end else begin
            t = longint'($signed(macc)) + longint'($signed(a));
            u = {1'b0, macc} + {1'b0, a};
            e.c = u[32];
        end
        e.o = t > MAXS || t < MINS;
        e.sum = t[31:0];
`ifdef ADDER_SAT_EN
        if (e.o) e.sum = t > 0 ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        if (o == 2'd2) macc = e.sum;
        e.acc = macc;
        return e;
    endfunction

    task automatic step(input bit v, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit ordy, output bit took);
        exp_t e;
        in_valid  = v;
        in_op     = o;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        took = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
            else begin
                e = q.pop_front();
                chk("sum", out_sum, e.sum);
                chk("carry", {31'd0, out_carry}, {31'd0, e.c});
                chk("ovf", {31'd0, out_ovf}, {31'd0, e.o});
                chk("zero", {31'd0, out_zero}, {31'd0, e.sum == 32'd0});
                chk("acc_value", acc_value, e.acc);
            end
        end
        if (took) q.push_back(model(o, a, b));
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        bit t;
        step(1'b0, 2'($urandom), $urandom, $urandom, ordy, t);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        chk("drain_timeout", q.size(), 32'd0);
    endtask

    initial begin
        bit t;
        int sent;
        int n;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
        chk("rst_acc", acc_value, ACC_INIT);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // latency: accepted on one edge, visible after the next
        step(1'b1, 2'd0, 32'd5, 32'd3, 1'b1, t);
        chk("lat_accept", {31'd0, t}, 32'd1);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_sum", out_sum, 32'd8);
        drain();

        step(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h1, 1'b1, t);
        step(1'b1, 2'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, t);
        step(1'b1, 2'd1, 32'd3, 32'd5, 1'b1, t);
        step(1'b1, 2'd1, 32'd5, 32'd3, 1'b1, t);
        step(1'b1, 2'd1, 32'd0, 32'h8000_0000, 1'b1, t);
        step(1'b1, 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, t);
        drain();

        // back-to-back ACC/CLR at full rate
        step(1'b1, 2'd2, 32'd10, $urandom, 1'b1, t);
        step(1'b1, 2'd2, 32'd20, $urandom, 1'b1, t);
        step(1'b1, 2'd2, 32'd30, $urandom, 1'b1, t);
        step(1'b1, 2'd3, $urandom, $urandom, 1'b1, t);
        chk("b2b_valid0", {31'd0, out_valid}, 32'd1);
        idle(1'b1);
        chk("b2b_valid1", {31'd0, out_valid}, 32'd1);
        idle(1'b1);
        chk("clr_acc", acc_value, ACC_INIT);
        drain();

        // backpressure
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd0, 32'(sent) * 32'h1111_1111, 32'(sent), 1'b0, t);
            if (t) sent++;
        end
        chk("bp_accepted", sent, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_held_sum", out_sum, 32'd0);
        n = 0;
        while (sent < 8 && n < 50) begin
            step(1'b1, 2'd0, 32'(sent) * 32'h1111_1111, 32'(sent), 1'b1, t);
            if (t) sent++;
            n++;
        end
        chk("bp_all_sent", sent, 32'd8);
        drain();

        for (int i = 0; i < 60; i++) begin
            step($urandom_range(3) != 0, 2'($urandom),
                 $urandom_range(1) != 0 ? $urandom : 32'($urandom_range(7)),
                 $urandom_range(1) != 0 ? $urandom : 32'($urandom_range(7)),
                 $urandom_range(2) != 0, t);
        end
        drain();

        // async reset with both stages full
        step(1'b1, 2'd3, $urandom, $urandom, 1'b1, t);
        step(1'b1, 2'd2, 32'd60, $urandom, 1'b1, t);
        drain();
        chk("pre_rst_acc", acc_value, 32'd60);
        step(1'b1, 2'd2, 32'd1, 32'd0, 1'b0, t);
        step(1'b1, 2'd2, 32'd2, 32'd0, 1'b0, t);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_acc", acc_value, ACC_INIT);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        macc = ACC_INIT;
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        step(1'b1, 2'd2, 32'd7, 32'd0, 1'b1, t);
        step(1'b1, 2'd0, 32'd5, 32'd3, 1'b1, t);
        drain();
        chk("post_rst_acc", acc_value, ACC_INIT + 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
